// File: rtl/contador_pkg.sv
// Shared definitions for the down-counter family: default width, the
// all-ones reset value helper and the JK command encoding {J,K}.
package contador_pkg;

  localparam int WIDTH_DEFAULT = 6;
  localparam int WIDTH_MAX     = 16;

  // JK command encoding, packed as {J, K}
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // All-ones value for a counter of the given width (upper bits zero)
  function automatic logic [WIDTH_MAX-1:0] reset_value(input int width);
    logic [WIDTH_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH_MAX; i++) begin
      if (i < width) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/contador_decrescente_6bits_jk_ff_rst.sv
// Falling-edge JK flip-flop with asynchronous active-low reset.
// PRESET selects the value forced while rst_n is low.
module jk_ff_rst
  import contador_pkg::*;
#(
  parameter logic PRESET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_reg;

  // JK behaviour on the falling edge; reset overrides asynchronously
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= PRESET;
    end else begin
      case ({j, k})
        JK_HOLD:  q_reg <= q_reg;
        JK_RESET: q_reg <= 1'b0;
        JK_SET:   q_reg <= 1'b1;
        default:  q_reg <= ~q_reg;
      endcase
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/contador_decrescente_6bits.sv
// Synchronous down counter built from JK flip-flops, all clocked by clk.
// Parallel load beats count enable; tc drives the next stage's en when
// cascading, so tc is high only in the cycle that will wrap 0 -> all ones.
module contador_decrescente_6bits
  import contador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             tc
);

  localparam logic [WIDTH_MAX-1:0] RST_VAL = reset_value(WIDTH);

  logic [WIDTH-1:0] q_bits;
  logic [WIDTH-1:0] t_chain;

  // Bit i toggles when every lower bit is 0 (borrow propagation)
  assign t_chain[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_toggle
      assign t_chain[gi] = t_chain[gi-1] & ~q_bits[gi-1];
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [1:0] jk_cmd;

      // Per-bit JK command: load forces d, en toggles along the chain
      always_comb begin
        jk_cmd = JK_HOLD;
        if (load) begin
          jk_cmd = d[gi] ? JK_SET : JK_RESET;
        end else if (en) begin
          jk_cmd = t_chain[gi] ? JK_TOGGLE : JK_HOLD;
        end
      end

      jk_ff_rst #(
        .PRESET (RST_VAL[gi])
      ) u_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .j     (jk_cmd[1]),
        .k     (jk_cmd[0]),
        .q     (q_bits[gi])
      );
    end
  endgenerate

  assign q    = q_bits;
  assign zero = (q_bits == '0);
  assign tc   = en & ~load & zero;

endmodule

// File: tb/tb_contador_decrescente_6bits.sv
// Bench for the JK down counter: directed scenarios, a random phase and a
// two-stage cascade, all checked against an arithmetic reference model.
module tb_contador_decrescente_6bits;

  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         zero;
  logic         tc;

  // cascade pair
  logic         rst_c;
  logic [W-1:0] lo_q, hi_q;
  logic         lo_zero, hi_zero, lo_tc, hi_tc;
  logic [W-1:0] cas_d;

  int n_assert = 0;
  int n_fail   = 0;
  int ref_q;
  int n_step   = 0;

  contador_decrescente_6bits #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .d     (d),
    .q     (q),
    .zero  (zero),
    .tc    (tc)
  );

  contador_decrescente_6bits #(.WIDTH(W)) cas_lo (
    .clk   (clk),
    .rst_n (rst_c),
    .en    (1'b1),
    .load  (1'b0),
    .d     (cas_d),
    .q     (lo_q),
    .zero  (lo_zero),
    .tc    (lo_tc)
  );

  contador_decrescente_6bits #(.WIDTH(W)) cas_hi (
    .clk   (clk),
    .rst_n (rst_c),
    .en    (lo_tc),
    .load  (1'b0),
    .d     (cas_d),
    .q     (hi_q),
    .zero  (hi_zero),
    .tc    (hi_tc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One transaction: drive after the rising edge, check the combinational
  // outputs, let the falling edge act, then check the new count.
  task automatic step(input logic e, input logic l, input logic [W-1:0] dv);
    @(posedge clk);
    #1;
    en = e; load = l; d = dv;
    #1;
    chk("zero_pre", {15'd0, zero}, {15'd0, ref_q == 0});
    chk("tc_pre",   {15'd0, tc},   {15'd0, e & ~l & (ref_q == 0)});
    @(negedge clk);
    if (l)      ref_q = int'(dv);
    else if (e) ref_q = (ref_q + 63) % 64;
    #1;
    chk("q", {10'd0, q}, 16'(ref_q));
    chk("zero_post", {15'd0, zero}, {15'd0, ref_q == 0});
    n_step++;
    $display("step %0d en=%0b load=%0b d=%0d q=%0d zero=%0b ref=%0d",
             n_step, e, l, dv, q, zero, ref_q);
  endtask

  initial begin
    rst_n = 1'b0; rst_c = 1'b0;
    en = 1'b0; load = 1'b0; d = '0; cas_d = '0;
    ref_q = 63;

    // reset state
    #25;
    chk("rst_q",    {10'd0, q}, 16'd63);
    chk("rst_zero", {15'd0, zero}, 16'd0);
    chk("rst_tc",   {15'd0, tc}, 16'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // free count through a full wrap
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, '0);
    chk("free_wrap", {10'd0, q}, 16'd63);

    // down to 40, then load with en also high
    for (int i = 0; i < 23; i++) step(1'b1, 1'b0, '0);
    chk("at40", {10'd0, q}, 16'd40);
    step(1'b1, 1'b1, 6'd5);
    chk("load5", {10'd0, q}, 16'd5);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    chk("after_load_wrap", {10'd0, q}, 16'd63);

    // hold at 17
    for (int i = 0; i < 46; i++) step(1'b1, 1'b0, '0);
    chk("at17", {10'd0, q}, 16'd17);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 6'(i * 7));
    chk("hold17", {10'd0, q}, 16'd17);
    step(1'b1, 1'b0, '0);
    chk("resume16", {10'd0, q}, 16'd16);

    // asynchronous reset between edges with a load pending at q = 9
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0);
    chk("at9", {10'd0, q}, 16'd9);
    @(posedge clk);
    #1 load = 1'b1; d = 6'd20; en = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_q",    {10'd0, q}, 16'd63);
    chk("async_zero", {15'd0, zero}, 16'd0);
    chk("async_tc",   {15'd0, tc}, 16'd0);
    #2 rst_n = 1'b1;
    load = 1'b0; en = 1'b1;
    ref_q = 63;
    #1 chk("async_hold", {10'd0, q}, 16'd63);
    @(negedge clk);
    #1 chk("async_next", {10'd0, q}, 16'd62);
    ref_q = 62;

    // load zero, then tc follows en
    step(1'b0, 1'b1, 6'd0);
    chk("load0_zero", {15'd0, zero}, 16'd1);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);

    // random phase
    for (int i = 0; i < 250; i++) begin
      logic         e, l;
      logic [W-1:0] dv;
      e  = 1'($urandom_range(0, 3) != 0);
      l  = 1'($urandom_range(0, 7) == 0);
      dv = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      step(e, l, dv);
    end

    // cascade: two stages act as one 12-bit down counter
    en = 1'b0; load = 1'b0;
    @(posedge clk); #1 rst_c = 1'b1;
    chk("cas_rst_lo", {10'd0, lo_q}, 16'd63);
    chk("cas_rst_hi", {10'd0, hi_q}, 16'd63);
    for (int n = 1; n <= 4096; n++) begin
      int exp12;
      @(negedge clk);
      #1;
      exp12 = (4095 - n) & 4095;
      chk("cas_lo", {10'd0, lo_q}, 16'(exp12 % 64));
      chk("cas_hi", {10'd0, hi_q}, 16'(exp12 / 64));
      if (n == 64) begin
        chk("cas64_hi", {10'd0, hi_q}, 16'd62);
        chk("cas64_lo", {10'd0, lo_q}, 16'd63);
        $display("cascade after 64 edges hi=%0d lo=%0d", hi_q, lo_q);
      end
    end
    chk("cas4096_hi", {10'd0, hi_q}, 16'd63);
    chk("cas4096_lo", {10'd0, lo_q}, 16'd63);
    $display("cascade after 4096 edges hi=%0d lo=%0d", hi_q, lo_q);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
